// File: rtl/mux_seq_serializer.sv
// Drives a quad 2:1 mux to read channel A then B, packs both nibbles and shifts the word out LSB first.
// Optional even-parity trailer bit is compiled in with `define MUX_SEQ_PARITY_EN.
module mux_seq_serializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] y_in,
    output logic             mux_s,
    output logic             mux_e_n,
    output logic             ser_data,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             busy,
    output logic             done
);

    localparam int WW = 2 * WIDTH;
    localparam int CW = $clog2(WW + 1);
`ifdef MUX_SEQ_PARITY_EN
    localparam logic [CW-1:0] LAST_BIT = CW'(WW);
`else
    localparam logic [CW-1:0] LAST_BIT = CW'(WW - 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAP_A,
        ST_CAP_B,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [WW-1:0]  word_q, word_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           bit_out;

`ifdef MUX_SEQ_PARITY_EN
    logic parity_q, parity_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    always_comb begin
        parity_d = parity_q;
        if (state_q == ST_CAP_B) begin
            parity_d = ^{y_in, word_q[WIDTH-1:0]};
        end
    end

    // The data bits have all shifted out by the time the parity slot comes up.
    assign bit_out = (cnt_q == CW'(WW)) ? parity_q : word_q[0];
`else
    assign bit_out = word_q[0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CAP_A;
                    cnt_d   = '0;
                end
            end
            ST_CAP_A: begin
                word_d[WIDTH-1:0] = y_in;
                state_d           = ST_CAP_B;
            end
            ST_CAP_B: begin
                word_d[WW-1:WIDTH] = y_in;
                state_d            = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (ser_ready) begin
                    word_d = word_q >> 1;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == LAST_BIT) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Every output is a decode of registered state, so ser_ready/y_in never reach an output.
    assign mux_e_n   = !((state_q == ST_CAP_A) || (state_q == ST_CAP_B));
    assign mux_s     = (state_q == ST_CAP_B);
    assign ser_valid = (state_q == ST_SHIFT);
    assign ser_data  = (state_q == ST_SHIFT) && bit_out;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_mux_seq_serializer.sv
// Scoreboard bench for mux_seq_serializer: stimulus tasks queue expected bits, a negedge monitor checks them.
module tb_mux_seq_serializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       ser_ready = 1'b1;
    logic [3:0] y_in;
    logic       mux_s, mux_e_n, ser_data, ser_valid, busy, done;
    logic [3:0] a_val = 4'h0;
    logic [3:0] b_val = 4'h0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int ready_mode = 0;
    int done_cnt = 0;
    int acc_cnt = 0;
    bit exp_q[$];
    logic prev_stall = 1'b0;
    logic prev_data = 1'b0;

`ifdef MUX_SEQ_PARITY_EN
    localparam int LAT = 11;
`else
    localparam int LAT = 10;
`endif

    mux_seq_serializer #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .y_in(y_in),
        .mux_s(mux_s), .mux_e_n(mux_e_n), .ser_data(ser_data),
        .ser_valid(ser_valid), .ser_ready(ser_ready), .busy(busy), .done(done)
    );

    // Behavioural quad 2:1 mux with active-low enable.
    assign y_in = mux_e_n ? 4'h0 : (mux_s ? b_val : a_val);

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        ser_ready = (ready_mode == 0) ? 1'b1 : (((cyc / 3) % 2) == 1);
    end

    // Monitor: compares every accepted bit against the scoreboard and checks hold under backpressure.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (prev_stall) begin
                check("hold_valid", ser_valid, 1);
                check("hold_data", ser_data, prev_data);
            end
            if (ser_valid && ser_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_bit: got bit %0d, expected none", ser_data);
                end else begin
                    bit e;
                    e = exp_q.pop_front();
                    check("ser_bit", ser_data, e);
                    $display("bit %0d accepted: data=%0d expected=%0d", acc_cnt, ser_data, e);
                end
                acc_cnt++;
            end
            prev_stall = ser_valid && !ser_ready;
            prev_data  = ser_data;
            if (done) done_cnt++;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic push_word(input logic [7:0] w, input logic par);
        for (int i = 0; i < 8; i++) exp_q.push_back(w[i]);
`ifdef MUX_SEQ_PARITY_EN
        exp_q.push_back(par);
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mux_e_n"}, mux_e_n, 1);
        check({tag, "_mux_s"}, mux_s, 0);
        check({tag, "_ser_valid"}, ser_valid, 0);
        check({tag, "_ser_data"}, ser_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    task automatic run_txn(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp_word,
                           input logic exp_par, input int mode, input bit spam, input int exp_lat);
        int st;
        int en_cnt;
        int got;
        logic [1:0] sseq;
        a_val = a;
        b_val = b;
        ready_mode = mode;
        push_word(exp_word, exp_par);
        @(negedge clk);
        start = 1'b1;
        st = cyc + 1;
        en_cnt = 0;
        got = 0;
        sseq = 2'b00;
        for (int t = 0; t < 300 && got == 0; t++) begin
            @(negedge clk);
            if (!spam) start = 1'b0;
            if (!mux_e_n) begin
                en_cnt++;
                sseq = {sseq[0], mux_s};
            end
            if (done) got = 1;
        end
        start = 1'b0;
        check("done_seen", got, 1);
        if (got == 1) begin
            if (exp_lat > 0) check("done_latency", cyc - st, exp_lat);
            check("busy_at_done", busy, 1);
        end
        check("mux_en_cycles", en_cnt, 2);
        check("mux_s_sequence", sseq, 1);
        check("bits_left", exp_q.size(), 0);
        exp_q.delete();
        $display("txn A=%0d B=%0d mode=%0d spam=%0d: done=%0d latency=%0d en_cycles=%0d",
                 a, b, mode, spam, got, cyc - st, en_cnt);
        @(negedge clk);
        check("busy_after_done", busy, 0);
        check("done_single_pulse", done, 0);
        if (spam) begin
            repeat (3) begin
                @(negedge clk);
                check("idle_after_spam", busy, 0);
            end
        end
    endtask

    task automatic reset_mid_txn();
        int done0;
        int acc0;
        int tries;
        a_val = 4'hF;
        b_val = 4'hA;
        ready_mode = 0;
        push_word(8'hAF, 1'b0);
        done0 = done_cnt;
        acc0 = acc_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tries = 0;
        while ((acc_cnt - acc0) < 2 && tries < 50) begin
            @(negedge clk);
            tries++;
        end
        check("reach_third_bit", ((acc_cnt - acc0) >= 2) ? 1 : 0, 1);
        @(posedge clk);
        #2;
        check("pre_reset_valid", ser_valid, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        $display("reset asserted mid-shift after %0d bits", acc_cnt - acc0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("no_done_on_abort", done_cnt, done0);
        check_reset_outputs("post_rst");
    endtask

    initial begin
        #3;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("idle");

        run_txn(4'd0,  4'd10, 8'hA0, 1'b0, 0, 1'b0, LAT);
        run_txn(4'd15, 4'd10, 8'hAF, 1'b0, 1, 1'b0, 0);
        run_txn(4'd15, 4'd10, 8'hAF, 1'b0, 0, 1'b1, LAT);
        reset_mid_txn();
        run_txn(4'd3,  4'd12, 8'hC3, 1'b0, 0, 1'b0, LAT);
        run_txn(4'd1,  4'd0,  8'h01, 1'b1, 0, 1'b0, LAT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
